demapper_sync: RTL and testbench
================================

// Module: demapper_sync
// PURPOSE
//  Parametrised receive demapper with its own frame alignment. Locks to the FAS byte
//  in the raw byte stream from the serial receiver. Strips overhead and forwards payload
//  to the client FIFO. Extracts the ARQ bit and checks each frame's payload CRC-8
//  against the value carried in the next frame. Replaces externally-flagged FAS framing.
// PARAMETERS
//  ROWS        4      rows per frame (>=2)
//  COLS        1024   columns (bytes) per row (> OH_COLS)
//  OH_COLS     2      overhead columns at start of each row (>=2)
//  FAS_BYTE    8'hF6  frame alignment byte, position row0/col0
//  SYNC_ENTER  2      consecutive good FAS (after the hunt hit) needed to declare SYNC
//  SYNC_LOSS   3      consecutive bad FAS in SYNC needed to drop to HUNT
// PORTS
//  i_clk               in   1  clock
//  i_rst               in   1  synchronous reset, active high
//  i_frame_data        in   8  line byte
//  i_frame_data_valid  in   1  line byte qualifier; no backpressure
//  o_pyld_data         out  8  payload byte to client
//  o_pyld_data_valid   out  1  payload qualifier
//  o_arq_en            out  1  ARQ enable (bit0 of ARQ byte)
//  o_arq_en_valid      out  1  1-cycle pulse with o_arq_en
//  o_crc_err           out  1  1 = received CRC != computed CRC
//  o_crc_err_valid     out  1  1-cycle pulse with o_crc_err
//  o_crc_val           out  8  computed CRC of last completed frame
//  o_lock              out  1  1 while state == SYNC
//  o_state             out  2  0 HUNT, 1 PRESYNC, 2 SYNC
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: state HUNT; row/col/good/miss counters 0; all outputs 0; CRC accumulator 0.
//  - Position counter (row,col) advances only on i_frame_data_valid.
//    col wraps COLS-1->0 with row+1; row wraps ROWS-1->0. Valid gaps freeze everything.
//  - HUNT: every valid byte is compared to FAS_BYTE. On match, position := (0,1) for
//    the next byte, good := 0, state -> PRESYNC.
//  - PRESYNC: at (0,0), match -> good+1, and good reaching SYNC_ENTER -> SYNC;
//    mismatch -> HUNT, with the same byte re-evaluated as a hunt candidate.
//  - SYNC: at (0,0), match -> miss := 0; mismatch -> miss+1;
//    miss == SYNC_LOSS -> HUNT immediately, and that frame is dropped.
//  - Outputs are active only while state == SYNC, including the FAS byte that enters
//    SYNC. All outputs are registered with 1 cycle of latency from the input byte.
//  - Payload: bytes with col >= OH_COLS -> o_pyld_data/o_pyld_data_valid.
//  - ARQ byte at (0,1) -> o_arq_en = byte[0], o_arq_en_valid pulse.
//  - CRC-8: poly 0x07, init 0x00, MSB first, over all payload bytes of a frame.
//    At the last byte (ROWS-1,COLS-1) the result is latched to o_crc_val and the
//    accumulator is reset to 0.
//  - CRC byte at (1,0) carries the previous frame's CRC. It is compared to o_crc_val,
//    producing o_crc_err and an o_crc_err_valid pulse. No check is made for the first
//    frame after entering SYNC, because no complete prior frame is marked "checkable".
//  - Other overhead bytes are discarded.
//  - SYNC->HUNT cancels the pending check and clears the checkable flag.
//  - Reset mid-frame: behaves as above; a partial payload burst is simply truncated.
// CONFIGURATION
//  DEMAP_ERR_CNT_EN defined: adds output o_crc_err_cnt [15:0].
//   - Incremented on each o_crc_err_valid with o_crc_err = 1; saturates at 16'hFFFF.
//   - Cleared by i_rst only.
//  DEMAP_ERR_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (ROWS=4, COLS=16, OH_COLS=2 unless stated)
//  1 Reset, 3 clean frames with F6 at frame start, continuous valid -> o_state 0->1->2.
//    o_lock rises at frame-3 FAS byte +1 cycle. Payload: 14 bytes/row, 56/frame, order kept.
//  2 Random 0..3-cycle valid gaps in locked stream -> identical payload sequence;
//    no output pulses during gaps.
//  3 Locked; frame N+1 (1,0) = correct CRC -> o_crc_err_valid=1, o_crc_err=0.
//    Flip one payload bit in frame N+2 -> o_crc_err=1 at frame N+3 (1,0) +1 cycle.
//  4 Locked; corrupt FAS in 2 frames, then clean -> stays SYNC.
//    Corrupt FAS in 3 frames -> HUNT at 3rd FAS +1 cycle; payload of that frame absent.
//  5 ARQ byte 8'h01 then 8'h00 -> o_arq_en_valid pulses with o_arq_en 1 then 0;
//    no pulses while in HUNT/PRESYNC.
//  6 i_rst asserted mid-payload in SYNC -> next cycle all outputs 0, o_state=0;
//    with DEMAP_ERR_CNT_EN defined the counter reads 0.

Source files
------------

// File: rtl/demapper_sync.sv
// demapper_sync: self-aligning receive demapper (FAS hunt, overhead strip, ARQ extract, CRC-8 check).
// Define DEMAP_ERR_CNT_EN to add the saturating CRC error counter output o_crc_err_cnt.
module demapper_sync #(
  parameter int         ROWS       = 4,
  parameter int         COLS       = 1024,
  parameter int         OH_COLS    = 2,
  parameter logic [7:0] FAS_BYTE   = 8'hF6,
  parameter int         SYNC_ENTER = 2,
  parameter int         SYNC_LOSS  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_frame_data,
  input  logic        i_frame_data_valid,
  output logic [7:0]  o_pyld_data,
  output logic        o_pyld_data_valid,
  output logic        o_arq_en,
  output logic        o_arq_en_valid,
  output logic        o_crc_err,
  output logic        o_crc_err_valid,
  output logic [7:0]  o_crc_val,
  output logic        o_lock,
  output logic [1:0]  o_state
`ifdef DEMAP_ERR_CNT_EN
  ,
  output logic [15:0] o_crc_err_cnt
`endif
);

  typedef enum logic [1:0] {HUNT = 2'd0, PRESYNC = 2'd1, SYNC = 2'd2} state_t;

  localparam int            RW       = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int            CW       = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] OH_LIM   = CW'(OH_COLS);
  localparam logic [7:0]    ENTER_N  = 8'(SYNC_ENTER);
  localparam logic [7:0]    LOSS_N   = 8'(SYNC_LOSS);

  // CRC-8, polynomial 0x07, MSB first
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

`ifdef DEMAP_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] err_cnt_p1;
  assign o_crc_err_cnt = err_cnt_p1;
`endif

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [7:0]    good_cnt;
  logic [7:0]    miss_cnt;
  logic [7:0]    crc_acc;
  logic          checkable;

  logic [7:0] pyld_data_p1;
  logic       vld_pyld_p1;
  logic       arq_p1;
  logic       vld_arq_p1;
  logic       crc_err_p1;
  logic       vld_crc_p1;
  logic [7:0] crc_val_p1;
  logic       lock_p1;

  logic       fas_pos, fas_hit, frame_end, pyld_pos;
  logic       enter_sync, lose_sync, active;
  logic [7:0] crc_nxt;

  // Stage p0: position decode and frame-alignment decisions for the incoming byte
  always_comb begin
    fas_pos    = (row == '0) && (col == '0);
    fas_hit    = (i_frame_data == FAS_BYTE);
    frame_end  = (row == ROW_LAST) && (col == COL_LAST);
    pyld_pos   = (col >= OH_LIM);
    enter_sync = (state == PRESYNC) && fas_pos && fas_hit && ((good_cnt + 8'd1) == ENTER_N);
    lose_sync  = (state == SYNC) && fas_pos && !fas_hit && ((miss_cnt + 8'd1) == LOSS_N);
    // The FAS byte that enters SYNC already counts as locked; the one that loses it does not.
    active     = ((state == SYNC) && !lose_sync) || enter_sync;
    crc_nxt    = crc8_step(crc_acc, i_frame_data);
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= HUNT;
      row          <= '0;
      col          <= '0;
      good_cnt     <= '0;
      miss_cnt     <= '0;
      crc_acc      <= '0;
      checkable    <= 1'b0;
      pyld_data_p1 <= '0;
      vld_pyld_p1  <= 1'b0;
      arq_p1       <= 1'b0;
      vld_arq_p1   <= 1'b0;
      crc_err_p1   <= 1'b0;
      vld_crc_p1   <= 1'b0;
      crc_val_p1   <= '0;
      lock_p1      <= 1'b0;
`ifdef DEMAP_ERR_CNT_EN
      err_cnt_p1   <= '0;
`endif
    end else begin
      vld_pyld_p1 <= 1'b0;
      vld_arq_p1  <= 1'b0;
      vld_crc_p1  <= 1'b0;
      if (i_frame_data_valid) begin
        case (state)
          HUNT: begin
            if (fas_hit) begin
              state    <= PRESYNC;
              good_cnt <= '0;
              row      <= '0;
              col      <= CW'(1);
            end
          end
          PRESYNC, SYNC: begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (fas_pos && state == PRESYNC) begin
              // A mismatching byte is never a FAS, so re-hunting it just stays in HUNT.
              if (!fas_hit) begin
                state <= HUNT;
              end else begin
                good_cnt <= good_cnt + 8'd1;
                if (enter_sync) begin
                  state    <= SYNC;
                  miss_cnt <= '0;
                  lock_p1  <= 1'b1;
                end
              end
            end else if (fas_pos) begin
              if (fas_hit) begin
                miss_cnt <= '0;
              end else if (lose_sync) begin
                state     <= HUNT;
                miss_cnt  <= '0;
                checkable <= 1'b0;
                lock_p1   <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase

        if (active) begin
          if (pyld_pos) begin
            pyld_data_p1 <= i_frame_data;
            vld_pyld_p1  <= 1'b1;
            if (frame_end) begin
              crc_val_p1 <= crc_nxt;
              crc_acc    <= '0;
              checkable  <= 1'b1;
            end else begin
              crc_acc <= crc_nxt;
            end
          end
          if (row == '0 && col == CW'(1)) begin
            arq_p1     <= i_frame_data[0];
            vld_arq_p1 <= 1'b1;
          end
          if (row == RW'(1) && col == '0 && checkable) begin
            crc_err_p1 <= (i_frame_data != crc_val_p1);
            vld_crc_p1 <= 1'b1;
`ifdef DEMAP_ERR_CNT_EN
            if (i_frame_data != crc_val_p1) err_cnt_p1 <= sat_inc16(err_cnt_p1);
`endif
          end
        end else begin
          crc_acc <= '0;
        end
      end
    end
  end

  assign o_pyld_data       = pyld_data_p1;
  assign o_pyld_data_valid = vld_pyld_p1;
  assign o_arq_en          = arq_p1;
  assign o_arq_en_valid    = vld_arq_p1;
  assign o_crc_err         = crc_err_p1;
  assign o_crc_err_valid   = vld_crc_p1;
  assign o_crc_val         = crc_val_p1;
  assign o_lock            = lock_p1;
  assign o_state           = state;

endmodule

// File: tb/tb_demapper_sync.sv
// Scoreboard bench for demapper_sync: frame-level alignment model plus payload/ARQ/CRC queues.
module tb_demapper_sync;
  localparam int         ROWS = 4;
  localparam int         COLS = 16;
  localparam int         OH   = 2;
  localparam int         NPL  = (COLS - OH) * ROWS;
  localparam int         FLEN = ROWS * COLS;
  localparam logic [7:0] FAS  = 8'hF6;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_frame_data;
  logic       i_frame_data_valid;
  logic [7:0] o_pyld_data;
  logic       o_pyld_data_valid;
  logic       o_arq_en;
  logic       o_arq_en_valid;
  logic       o_crc_err;
  logic       o_crc_err_valid;
  logic [7:0] o_crc_val;
  logic       o_lock;
  logic [1:0] o_state;
`ifdef DEMAP_ERR_CNT_EN
  logic [15:0] o_crc_err_cnt;
`endif

  always #5 clk = ~clk;

  demapper_sync #(
    .ROWS(ROWS), .COLS(COLS), .OH_COLS(OH), .FAS_BYTE(FAS), .SYNC_ENTER(2), .SYNC_LOSS(3)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_frame_data(i_frame_data),
    .i_frame_data_valid(i_frame_data_valid),
    .o_pyld_data(o_pyld_data),
    .o_pyld_data_valid(o_pyld_data_valid),
    .o_arq_en(o_arq_en),
    .o_arq_en_valid(o_arq_en_valid),
    .o_crc_err(o_crc_err),
    .o_crc_err_valid(o_crc_err_valid),
    .o_crc_val(o_crc_val),
    .o_lock(o_lock),
    .o_state(o_state)
`ifdef DEMAP_ERR_CNT_EN
    ,
    .o_crc_err_cnt(o_crc_err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pq[$];
  logic       aq[$];
  logic       cq[$];

  int         m_state = 0;
  int         m_good  = 0;
  int         m_miss  = 0;
  bit         m_chkable = 1'b0;
  logic [7:0] m_crc_val = 8'h00;
  logic [7:0] prev_tx_crc = 8'h11;
  int         m_errcnt = 0;
  bit         pend = 1'b0;
  int         pend_state = 0;
  logic       vld_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference CRC as polynomial division of (crc ^ data) * x^8 by x^8+x^2+x+1
  function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = {c ^ d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic model_fas(input bit ok);
    case (m_state)
      0: if (ok) begin m_state = 1; m_good = 0; end
      1: if (ok) begin
           m_good++;
           if (m_good == 2) begin m_state = 2; m_miss = 0; end
         end else m_state = 0;
      default: if (ok) m_miss = 0;
         else begin
           m_miss++;
           if (m_miss == 3) begin m_state = 0; m_miss = 0; m_chkable = 1'b0; end
         end
    endcase
  endtask

  task automatic do_pending();
    if (pend) begin
      chk("state", 32'(o_state), 32'(pend_state));
      chk("lock", 32'(o_lock), 32'(pend_state == 2));
      pend = 1'b0;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
    repeat (g) begin
      @(negedge clk);
      do_pending();
      i_frame_data_valid = 1'b0;
    end
    @(negedge clk);
    do_pending();
    i_frame_data       = b;
    i_frame_data_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      do_pending();
      i_frame_data_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] fas, input logic [7:0] arq, input bit flip,
                            input int gapmax, input int nbytes);
    logic [7:0] tx[NPL];
    logic [7:0] rx[NPL];
    logic [7:0] tx_crc, rx_crc, b;
    bit         act;
    int         k, r, c;
    do begin
      tx_crc = 8'h00;
      for (int i = 0; i < NPL; i++) begin
        do tx[i] = 8'($urandom_range(0, 255));
        while (tx[i] == FAS || (tx[i] ^ 8'h08) == FAS);
        tx_crc = crc8_ref(tx_crc, tx[i]);
      end
    end while (tx_crc == FAS);
    rx = tx;
    if (flip) rx[5] = rx[5] ^ 8'h08;
    rx_crc = 8'h00;
    for (int i = 0; i < NPL; i++) rx_crc = crc8_ref(rx_crc, rx[i]);

    model_fas(fas == FAS);
    act = (m_state == 2);
    k = 0;
    for (int idx = 0; idx < nbytes; idx++) begin
      r = idx / COLS;
      c = idx % COLS;
      if (r == 0 && c == 0)      b = fas;
      else if (r == 0 && c == 1) b = arq;
      else if (r == 1 && c == 0) b = prev_tx_crc;
      else if (c < OH)           b = 8'h3C;
      else begin b = rx[k]; k++; end
      if (act) begin
        if (c >= OH) pq.push_back(b);
        if (r == 0 && c == 1) aq.push_back(b[0]);
        if (r == 1 && c == 0 && m_chkable) begin
          cq.push_back(b != m_crc_val);
          if (b != m_crc_val) m_errcnt++;
        end
      end
      drive_byte(b, gapmax);
      if (idx == 0) begin pend = 1'b1; pend_state = m_state; end
    end
    if (nbytes == FLEN) begin
      if (act) begin m_crc_val = rx_crc; m_chkable = 1'b1; end
      prev_tx_crc = tx_crc;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(o_state), 32'd0);
    chk({tag, "_lock"}, 32'(o_lock), 32'd0);
    chk({tag, "_pyld"}, 32'(o_pyld_data), 32'd0);
    chk({tag, "_pyld_vld"}, 32'(o_pyld_data_valid), 32'd0);
    chk({tag, "_arq"}, 32'(o_arq_en), 32'd0);
    chk({tag, "_arq_vld"}, 32'(o_arq_en_valid), 32'd0);
    chk({tag, "_crc_err"}, 32'(o_crc_err), 32'd0);
    chk({tag, "_crc_vld"}, 32'(o_crc_err_valid), 32'd0);
    chk({tag, "_crc_val"}, 32'(o_crc_val), 32'd0);
`ifdef DEMAP_ERR_CNT_EN
    chk({tag, "_err_cnt"}, 32'(o_crc_err_cnt), 32'd0);
`endif
  endtask

  always @(posedge clk) vld_seen <= i_frame_data_valid;

  always @(negedge clk) begin
    if (!vld_seen)
      chk("gap_quiet", 32'({o_pyld_data_valid, o_arq_en_valid, o_crc_err_valid}), 32'd0);
    if (o_pyld_data_valid) begin
      if (pq.size() > 0) chk("pyld", 32'(o_pyld_data), 32'(pq.pop_front()));
      else chk("pyld_unexpected", 32'd1, 32'd0);
    end
    if (o_arq_en_valid) begin
      if (aq.size() > 0) chk("arq", 32'(o_arq_en), 32'(aq.pop_front()));
      else chk("arq_unexpected", 32'd1, 32'd0);
    end
    if (o_crc_err_valid) begin
      if (cq.size() > 0) chk("crc_err", 32'(o_crc_err), 32'(cq.pop_front()));
      else chk("crc_unexpected", 32'd1, 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_frame_data = 8'h00;
    i_frame_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    i_rst = 1'b0;

    // Acquisition and clean locked frames, alternating ARQ
    for (int f = 0; f < 5; f++) send_frame(FAS, (f % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 0, FLEN);
    // Random valid gaps
    for (int f = 0; f < 3; f++) send_frame(FAS, 8'h01, 1'b0, 3, FLEN);
    // Good CRC, then a flipped payload bit, then detection and recovery
    send_frame(FAS, 8'h00, 1'b0, 0, FLEN);
    send_frame(FAS, 8'h01, 1'b1, 0, FLEN);
    send_frame(FAS, 8'h00, 1'b0, 0, FLEN);
    send_frame(FAS, 8'h01, 1'b0, 0, FLEN);
    // Two bad FAS tolerated, three drop lock, then re-acquire
    send_frame(8'h00, 8'h00, 1'b0, 0, FLEN);
    send_frame(8'h00, 8'h01, 1'b0, 0, FLEN);
    send_frame(FAS, 8'h00, 1'b0, 0, FLEN);
    for (int f = 0; f < 3; f++) send_frame(8'h00, 8'h01, 1'b0, 0, FLEN);
    for (int f = 0; f < 4; f++) send_frame(FAS, (f % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 1, FLEN);
`ifdef DEMAP_ERR_CNT_EN
    idle(1);
    chk("err_cnt", 32'(o_crc_err_cnt), 32'(m_errcnt));
`endif

    // Reset in the middle of a payload row
    send_frame(FAS, 8'h00, 1'b0, 0, 20);
    @(negedge clk);
    i_rst = 1'b1;
    i_frame_data_valid = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    m_state = 0; m_good = 0; m_miss = 0; m_chkable = 1'b0; m_crc_val = 8'h00; m_errcnt = 0;
    @(negedge clk);
    i_rst = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(FAS, (f % 2 == 0) ? 8'h01 : 8'h00, 1'b0, 0, FLEN);

    idle(5);
    chk("pyld_left", 32'(pq.size()), 32'd0);
    chk("arq_left", 32'(aq.size()), 32'd0);
    chk("crc_left", 32'(cq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
